// File: rtl/uart_ctrl_pkg.sv
// Shared encodings for the simpleuart register-port controller: FSM states and the
// "receive buffer empty" read value.
package uart_ctrl_pkg;

    localparam logic [31:0] UART_EMPTY = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_WRITE = 2'd1,
        TX_ACK   = 2'd2
    } tx_state_t;

    typedef enum logic {
        RX_POLL = 1'b0,
        RX_CLR  = 1'b1
    } rx_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request searching from i_ptr upwards,
// wrapping modulo NUM_REQ.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDW     = 1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDW-1:0]     i_ptr,
    output logic [IDW-1:0]     o_grant_id,
    output logic               o_valid
);

    int w_idx;

    // Walk from lowest to highest priority so the final write wins.
    always_comb begin
        o_grant_id = '0;
        o_valid    = 1'b0;
        w_idx      = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_idx = (int'(i_ptr) + k) % NUM_REQ;
            if (i_req[w_idx]) begin
                o_grant_id = IDW'(w_idx);
                o_valid    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_port_arbiter.sv
// Owns the simpleuart register port: round-robin byte writes from NUM_REQ requesters
// and an independent receive drain presented as a valid/ready stream.
module uart_port_arbiter
    import uart_ctrl_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDW     = 1
) (
    input  logic                 hw_clk,
    input  logic                 resetn,
    input  logic [NUM_REQ-1:0]   tx_req,
    input  logic [8*NUM_REQ-1:0] tx_data,
    output logic [NUM_REQ-1:0]   tx_ack,
    output logic                 tx_busy,
    output logic [IDW-1:0]       grant_id,
    output logic                 rx_valid,
    output logic [7:0]           rx_data,
    input  logic                 rx_ready,
    output logic                 uart_dat_we,
    output logic                 uart_dat_re,
    output logic [31:0]          uart_dat_di,
    input  logic [31:0]          uart_dat_do,
    input  logic                 uart_dat_wait
);

    tx_state_t          r_tx_state, w_tx_state_nxt;
    logic [NUM_REQ-1:0] r_tx_ack,   w_tx_ack_nxt;
    logic               r_tx_busy,  w_tx_busy_nxt;
    logic [IDW-1:0]     r_grant,    w_grant_nxt;
    logic [IDW-1:0]     r_rr_ptr,   w_rr_ptr_nxt;
    logic               r_we,       w_we_nxt;
    logic [7:0]         r_tx_byte,  w_tx_byte_nxt;

    rx_state_t          r_rx_state, w_rx_state_nxt;
    logic               r_rx_valid, w_rx_valid_nxt;
    logic [7:0]         r_rx_data,  w_rx_data_nxt;
    logic               r_re,       w_re_nxt;

    logic [IDW-1:0]     w_arb_id;
    logic               w_arb_valid;
    logic               w_unused_do;

    // Only the empty flag and the data byte of the receive word carry information.
    assign w_unused_do = ^uart_dat_do[30:8];

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_rr_arbiter (
        .i_req      (tx_req),
        .i_ptr      (r_rr_ptr),
        .o_grant_id (w_arb_id),
        .o_valid    (w_arb_valid)
    );

    // NOTE: every next-state variable gets a default before the case, so no path leaves one unassigned (no latches).
    always_comb begin
        w_tx_state_nxt = r_tx_state;
        w_tx_ack_nxt   = '0;
        w_tx_busy_nxt  = r_tx_busy;
        w_grant_nxt    = r_grant;
        w_rr_ptr_nxt   = r_rr_ptr;
        w_we_nxt       = r_we;
        w_tx_byte_nxt  = r_tx_byte;
        case (r_tx_state)
            TX_IDLE: begin
                if (w_arb_valid) begin
                    w_grant_nxt    = w_arb_id;
                    w_tx_byte_nxt  = tx_data[8*int'(w_arb_id) +: 8];
                    w_we_nxt       = 1'b1;
                    w_tx_busy_nxt  = 1'b1;
                    w_tx_state_nxt = TX_WRITE;
                end
            end
            TX_WRITE: begin
                if (!uart_dat_wait) begin
                    w_we_nxt              = 1'b0;
                    w_tx_ack_nxt[r_grant] = 1'b1;
                    w_rr_ptr_nxt          = (int'(r_grant) == NUM_REQ - 1) ? '0 : r_grant + IDW'(1);
                    w_tx_state_nxt        = TX_ACK;
                end
            end
            TX_ACK: begin
                w_tx_busy_nxt  = 1'b0;
                w_tx_state_nxt = TX_IDLE;
            end
            default: w_tx_state_nxt = TX_IDLE;
        endcase
    end

    // A held byte blocks further reads; the UART keeps the next one buffered meanwhile.
    always_comb begin
        w_rx_state_nxt = r_rx_state;
        w_rx_valid_nxt = r_rx_valid;
        w_rx_data_nxt  = r_rx_data;
        w_re_nxt       = 1'b0;
        if (r_rx_valid && rx_ready) begin
            w_rx_valid_nxt = 1'b0;
        end
        case (r_rx_state)
            RX_POLL: begin
                if (!r_rx_valid && !uart_dat_do[31]) begin
                    w_rx_data_nxt  = uart_dat_do[7:0];
                    w_rx_valid_nxt = 1'b1;
                    w_re_nxt       = 1'b1;
                    w_rx_state_nxt = RX_CLR;
                end
            end
            RX_CLR:  w_rx_state_nxt = RX_POLL;
            default: w_rx_state_nxt = RX_POLL;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge hw_clk) begin
        if (!resetn) begin
            r_tx_state <= TX_IDLE;
            r_tx_ack   <= '0;
            r_tx_busy  <= 1'b0;
            r_grant    <= '0;
            r_rr_ptr   <= '0;
            r_we       <= 1'b0;
            r_tx_byte  <= '0;
            r_rx_state <= RX_POLL;
            r_rx_valid <= 1'b0;
            r_rx_data  <= '0;
            r_re       <= 1'b0;
        end else begin
            r_tx_state <= w_tx_state_nxt;
            r_tx_ack   <= w_tx_ack_nxt;
            r_tx_busy  <= w_tx_busy_nxt;
            r_grant    <= w_grant_nxt;
            r_rr_ptr   <= w_rr_ptr_nxt;
            r_we       <= w_we_nxt;
            r_tx_byte  <= w_tx_byte_nxt;
            r_rx_state <= w_rx_state_nxt;
            r_rx_valid <= w_rx_valid_nxt;
            r_rx_data  <= w_rx_data_nxt;
            r_re       <= w_re_nxt;
        end
    end

    assign tx_ack      = r_tx_ack;
    assign tx_busy     = r_tx_busy;
    assign grant_id    = r_grant;
    assign uart_dat_we = r_we;
    assign uart_dat_di = {24'h0, r_tx_byte};
    assign uart_dat_re = r_re;
    assign rx_valid    = r_rx_valid;
    assign rx_data     = r_rx_data;

endmodule

// File: tb/tb_uart_port_arbiter.sv
// Self-checking bench for uart_port_arbiter with a small behavioural simpleuart model
// and write/receive scoreboards.
module tb_uart_port_arbiter;
    import uart_ctrl_pkg::*;

    localparam int NUM_REQ = 2;
    localparam int IDW     = 1;

    logic                 hw_clk = 1'b0;
    logic                 resetn;
    logic [NUM_REQ-1:0]   tx_req;
    logic [8*NUM_REQ-1:0] tx_data;
    logic [NUM_REQ-1:0]   tx_ack;
    logic                 tx_busy;
    logic [IDW-1:0]       grant_id;
    logic                 rx_valid;
    logic [7:0]           rx_data;
    logic                 rx_ready;
    logic                 uart_dat_we;
    logic                 uart_dat_re;
    logic [31:0]          uart_dat_di;
    logic [31:0]          uart_dat_do;
    logic                 uart_dat_wait;
    logic                 r_hold;

    always #5 hw_clk = ~hw_clk;

    // simpleuart raises wait combinationally on we while its shifter is busy.
    assign uart_dat_wait = uart_dat_we & r_hold;

    uart_port_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) dut (
        .hw_clk        (hw_clk),
        .resetn        (resetn),
        .tx_req        (tx_req),
        .tx_data       (tx_data),
        .tx_ack        (tx_ack),
        .tx_busy       (tx_busy),
        .grant_id      (grant_id),
        .rx_valid      (rx_valid),
        .rx_data       (rx_data),
        .rx_ready      (rx_ready),
        .uart_dat_we   (uart_dat_we),
        .uart_dat_re   (uart_dat_re),
        .uart_dat_di   (uart_dat_di),
        .uart_dat_do   (uart_dat_do),
        .uart_dat_wait (uart_dat_wait)
    );

    typedef struct {
        int         idx;
        logic [7:0] data;
    } tx_exp_t;

    typedef struct {
        logic [1:0] req;
        logic [7:0] d0;
        logic [7:0] d1;
        int         wait_cyc;
        int         exp_idx;
        logic [7:0] exp_byte;
    } tx_vec_t;

    tx_exp_t            tx_exp_q[$];
    logic [7:0]         rx_exp_q[$];
    logic [7:0]         rx_src_q[$];
    logic               rx_buf_valid;
    logic [7:0]         rx_buf;
    logic [NUM_REQ-1:0] ack_pending;
    int n_checks, n_errors;
    int wr_count, ack_count, re_count, rx_hs_count;
    tx_vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name, input logic [31:0] act);
        n_checks++;
        n_errors++;
        $display("FAIL %s: unexpected event, value 0x%0h", name, act);
    endtask

    // One clock cycle: observe at the falling edge, then update the UART model after the rising edge.
    task automatic tick();
        tx_exp_t    e;
        logic [7:0] rb;
        logic       re_seen;
        @(negedge hw_clk);
        re_seen = uart_dat_re;
        if (resetn) begin
            if (ack_pending != '0) begin
                check("tx_ack_pulse", 32'(tx_ack), 32'(ack_pending));
                ack_count++;
            end else if (tx_ack != '0) begin
                fail("tx_ack_unexpected", 32'(tx_ack));
            end
            ack_pending = '0;
            if (uart_dat_we && !uart_dat_wait) begin
                wr_count++;
                if (tx_exp_q.size() == 0) begin
                    fail("tx_write_unexpected", uart_dat_di);
                end else begin
                    e = tx_exp_q.pop_front();
                    check("tx_di", uart_dat_di, {24'h0, e.data});
                    check("tx_grant_id", 32'(grant_id), e.idx);
                    ack_pending = NUM_REQ'(1) << e.idx;
                end
            end
            if (uart_dat_re) re_count++;
            if (rx_valid && rx_ready) begin
                rx_hs_count++;
                if (rx_exp_q.size() == 0) begin
                    fail("rx_handshake_unexpected", 32'(rx_data));
                end else begin
                    rb = rx_exp_q.pop_front();
                    check("rx_data", 32'(rx_data), 32'(rb));
                end
            end
        end else begin
            ack_pending = '0;
        end
        @(posedge hw_clk);
        #1;
        if (re_seen) rx_buf_valid = 1'b0;
        if (!rx_buf_valid && rx_src_q.size() != 0) begin
            rx_buf       = rx_src_q.pop_front();
            rx_buf_valid = 1'b1;
        end
        uart_dat_do = rx_buf_valid ? {24'h0, rx_buf} : UART_EMPTY;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Single transaction: grant latency, optional wait stretch, one accepted write, one ack.
    task automatic run_vec(input tx_vec_t v);
        int   wr0;
        int   ack0;
        logic stable;
        wr0    = wr_count;
        ack0   = ack_count;
        stable = 1'b1;
        tx_data = {v.d1, v.d0};
        tx_req  = v.req;
        r_hold  = (v.wait_cyc != 0);
        tx_exp_q.push_back('{v.exp_idx, v.exp_byte});
        check("vec_we_before_grant", 32'(uart_dat_we), 0);
        tick();
        check("vec_we_after_grant", 32'(uart_dat_we), 1);
        check("vec_busy", 32'(tx_busy), 1);
        for (int k = 0; k < v.wait_cyc; k++) begin
            tick();
            if (!(uart_dat_we && uart_dat_di == {24'h0, v.exp_byte} && tx_busy)) stable = 1'b0;
        end
        check("vec_we_di_stable", 32'(stable), 1);
        r_hold = 1'b0;
        tick();
        tx_req = '0;
        tick();
        check("vec_busy_cleared", 32'(tx_busy), 0);
        ticks(2);
        check("vec_one_write", wr_count - wr0, 1);
        check("vec_one_ack", ack_count - ack0, 1);
        check("vec_queue_drained", tx_exp_q.size(), 0);
    endtask

    initial begin
        int wr0, ack0, re0, hs0;
        n_checks = 0;  n_errors = 0;
        wr_count = 0;  ack_count = 0; re_count = 0; rx_hs_count = 0;
        ack_pending  = '0;
        rx_buf_valid = 1'b0;
        rx_buf       = '0;
        uart_dat_do  = UART_EMPTY;
        resetn   = 1'b0;
        tx_req   = '0;
        tx_data  = '0;
        rx_ready = 1'b0;
        r_hold   = 1'b0;

        // Expected grant index and byte follow the rotating pointer, which starts at 0.
        vecs[0] = '{2'b01, 8'h50, 8'h00, 0, 0, 8'h50};
        vecs[1] = '{2'b11, 8'h11, 8'h22, 0, 1, 8'h22};
        vecs[2] = '{2'b11, 8'h33, 8'h44, 2, 0, 8'h33};
        vecs[3] = '{2'b01, 8'h55, 8'h00, 0, 0, 8'h55};
        vecs[4] = '{2'b10, 8'h00, 8'h66, 3, 1, 8'h66};
        vecs[5] = '{2'b10, 8'h00, 8'h77, 0, 1, 8'h77};
        vecs[6] = '{2'b11, 8'h88, 8'h99, 0, 0, 8'h88};
        vecs[7] = '{2'b11, 8'hAA, 8'hBB, 1, 1, 8'hBB};

        ticks(3);
        check("reset_tx_ack", 32'(tx_ack), 0);
        check("reset_tx_busy", 32'(tx_busy), 0);
        check("reset_grant_id", 32'(grant_id), 0);
        check("reset_we_re", {30'h0, uart_dat_we, uart_dat_re}, 0);
        check("reset_di", uart_dat_di, 0);
        check("reset_rx", {23'h0, rx_valid, rx_data}, 0);
        resetn = 1'b1;
        tick();

        foreach (vecs[i]) run_vec(vecs[i]);

        // Both requesters held: strict alternation A,B,A,B with a concurrent receive.
        wr0  = wr_count;
        ack0 = ack_count;
        re0  = re_count;
        hs0  = rx_hs_count;
        tx_data  = {8'h42, 8'h41};
        tx_req   = 2'b11;
        rx_ready = 1'b1;
        tx_exp_q.push_back('{0, 8'h41});
        tx_exp_q.push_back('{1, 8'h42});
        tx_exp_q.push_back('{0, 8'h41});
        tx_exp_q.push_back('{1, 8'h42});
        rx_src_q.push_back(8'h5A);
        rx_exp_q.push_back(8'h5A);
        for (int k = 0; k < 40 && wr_count < wr0 + 4; k++) tick();
        tx_req = '0;
        ticks(3);
        check("alt_writes", wr_count - wr0, 4);
        check("alt_acks", ack_count - ack0, 4);
        check("alt_queue", tx_exp_q.size(), 0);
        check("alt_rx_re", re_count - re0, 1);
        check("alt_rx_hs", rx_hs_count - hs0, 1);
        rx_ready = 1'b0;

        // Long wait stretch from a busy shifter.
        run_vec('{2'b01, 8'h5C, 8'h00, 1250, 0, 8'h5C});

        // Reset during a stretched write: abandoned, pointer back to 0, pending request served.
        tx_data = {8'hD2, 8'hD1};
        tx_req  = 2'b10;
        r_hold  = 1'b1;
        wr0     = wr_count;
        ticks(2);
        check("rst_pre_we", 32'(uart_dat_we), 1);
        check("rst_pre_grant", 32'(grant_id), 1);
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        check("rst_tx_ack", 32'(tx_ack), 0);
        check("rst_tx_busy", 32'(tx_busy), 0);
        check("rst_grant_id", 32'(grant_id), 0);
        check("rst_we_re", {30'h0, uart_dat_we, uart_dat_re}, 0);
        check("rst_di", uart_dat_di, 0);
        check("rst_rx", {23'h0, rx_valid, rx_data}, 0);
        r_hold = 1'b0;
        tx_req = 2'b11;
        tx_exp_q.push_back('{0, 8'hD1});
        tx_exp_q.push_back('{1, 8'hD2});
        for (int k = 0; k < 30 && (tx_req != '0 || tx_busy); k++) begin
            tick();
            tx_req = tx_req & ~tx_ack;
        end
        ticks(2);
        check("rst_writes", wr_count - wr0, 2);
        check("rst_queue", tx_exp_q.size(), 0);

        // Consumer stalled: one read, second byte stays buffered until the first is taken.
        re0 = re_count;
        hs0 = rx_hs_count;
        rx_src_q.push_back(8'h33);
        rx_src_q.push_back(8'h34);
        rx_exp_q.push_back(8'h33);
        rx_exp_q.push_back(8'h34);
        ticks(13);
        check("rx_stall_valid", 32'(rx_valid), 1);
        check("rx_stall_data", 32'(rx_data), 32'h33);
        check("rx_stall_re_once", re_count - re0, 1);
        rx_ready = 1'b1;
        for (int k = 0; k < 20 && rx_exp_q.size() != 0; k++) tick();
        ticks(2);
        check("rx_stall_hs", rx_hs_count - hs0, 2);
        check("rx_stall_re_total", re_count - re0, 2);
        check("rx_stall_valid_clear", 32'(rx_valid), 0);

        // Consumer always ready: back-to-back bytes in order.
        re0 = re_count;
        hs0 = rx_hs_count;
        rx_src_q.push_back(8'h31);
        rx_src_q.push_back(8'h32);
        rx_exp_q.push_back(8'h31);
        rx_exp_q.push_back(8'h32);
        ticks(10);
        check("rx_ready_hs", rx_hs_count - hs0, 2);
        check("rx_ready_re", re_count - re0, 2);
        check("rx_ready_queue", rx_exp_q.size(), 0);
        check("final_no_stray_write", tx_exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
